// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed seven-segment display controller for common-anode digits.
// Scans one digit per slot of 2**SLOT_LOG2 clocks, most-significant digit first.
// A loaded value waits in a pending register and reaches the display register only
// at a frame boundary, so a frame never mixes old and new digits.
//
// Ports:
//   CLK, RST    system clock, asynchronous active-high reset
//   value       hex nibbles, nibble k drives digit k
//   dots        per-digit decimal point request
//   load        one-cycle strobe capturing value/dots into the pending register
//   blank_zero  1 = blank leading zero digits (digit 0 never blanked)
//   brightness  on-window per slot; all-ones = full on
//   seg         {dp, g..a}, active-low, registered
//   dig         one-hot digit enable, active-high, registered
//   frame       one-cycle pulse on the first cycle of each scan frame
module seg_scan_display #(
    parameter int DIGITS    = 4,
    parameter int SLOT_LOG2 = 10,
    parameter int BRIGHT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dots,
    input  logic                  load,
    input  logic                  blank_zero,
    input  logic [BRIGHT_W-1:0]   brightness,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     dig,
    output logic                  frame
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] POS_LAST = IDX_W'(DIGITS - 1);

    // pos counts scan slots upward from 0; the digit shown is DIGITS-1-pos,
    // so a reset value of 0 starts the scan on the most-significant digit.
    logic [SLOT_LOG2-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0]     pos_q, pos_d;
    logic [4*DIGITS-1:0]  disp_val_q, disp_val_d;
    logic [DIGITS-1:0]    disp_dots_q, disp_dots_d;
    logic [4*DIGITS-1:0]  pend_val_q, pend_val_d;
    logic [DIGITS-1:0]    pend_dots_q, pend_dots_d;
    logic                 pend_flag_q, pend_flag_d;
    logic [7:0]           seg_q, seg_d;
    logic [DIGITS-1:0]    dig_q, dig_d;
    logic                 frame_q, frame_d;

    logic                 slot_end;
    logic                 frame_start;
    logic [IDX_W-1:0]     cur_dig;
    logic [3:0]           cur_nib;
    logic                 cur_dot;
    logic                 cur_blank;
    logic                 on_window;
    logic [DIGITS-1:0]    lead_zero;

    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'h40;
            4'h1: pat = 7'h79;
            4'h2: pat = 7'h24;
            4'h3: pat = 7'h30;
            4'h4: pat = 7'h19;
            4'h5: pat = 7'h12;
            4'h6: pat = 7'h02;
            4'h7: pat = 7'h78;
            4'h8: pat = 7'h00;
            4'h9: pat = 7'h10;
            4'hA: pat = 7'h08;
            4'hB: pat = 7'h03;
            4'hC: pat = 7'h46;
            4'hD: pat = 7'h21;
            4'hE: pat = 7'h06;
            default: pat = 7'h0E;
        endcase
        return pat;
    endfunction

    // Scan timing, frame boundary and pending/display registers.
    always_comb begin
        cnt_d       = cnt_q + 1'b1;
        slot_end    = &cnt_q;
        frame_start = slot_end && (pos_q == POS_LAST);
        frame_d     = frame_start;

        pos_d = pos_q;
        if (slot_end) begin
            pos_d = frame_start ? '0 : pos_q + 1'b1;
        end

        disp_val_d  = disp_val_q;
        disp_dots_d = disp_dots_q;
        pend_val_d  = pend_val_q;
        pend_dots_d = pend_dots_q;
        pend_flag_d = pend_flag_q;

        if (frame_start && pend_flag_q) begin
            disp_val_d  = pend_val_q;
            disp_dots_d = pend_dots_q;
            pend_flag_d = 1'b0;
        end
        // A load on the commit edge is applied after the commit, so it stays
        // pending for the following frame.
        if (load) begin
            pend_val_d  = value;
            pend_dots_d = dots;
            pend_flag_d = 1'b1;
        end
    end

    // Digit selection, blanking and brightness window.
    always_comb begin
        cur_dig = POS_LAST - pos_q;

        lead_zero = '0;
        lead_zero[DIGITS-1] = (disp_val_q[4*DIGITS-1 -: 4] == 4'h0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            lead_zero[k] = lead_zero[k+1] && (disp_val_q[4*k +: 4] == 4'h0);
        end

        on_window = (cnt_q[SLOT_LOG2-1 -: BRIGHT_W] <= brightness);

        cur_nib   = 4'h0;
        cur_dot   = 1'b0;
        cur_blank = 1'b0;
        dig_d     = '0;
        for (int k = 0; k < DIGITS; k++) begin
            if (IDX_W'(k) == cur_dig) begin
                cur_nib   = disp_val_q[4*k +: 4];
                cur_dot   = disp_dots_q[k];
                cur_blank = blank_zero && (k != 0) && lead_zero[k];
                dig_d[k]  = on_window;
            end
        end

        seg_d = 8'hFF;
        if (on_window) begin
            seg_d = {~cur_dot, cur_blank ? 7'h7F : hex7(cur_nib)};
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q       <= '0;
            pos_q       <= '0;
            disp_val_q  <= '0;
            disp_dots_q <= '0;
            pend_val_q  <= '0;
            pend_dots_q <= '0;
            pend_flag_q <= 1'b0;
            seg_q       <= 8'hFF;
            dig_q       <= '0;
            frame_q     <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            pos_q       <= pos_d;
            disp_val_q  <= disp_val_d;
            disp_dots_q <= disp_dots_d;
            pend_val_q  <= pend_val_d;
            pend_dots_q <= pend_dots_d;
            pend_flag_q <= pend_flag_d;
            seg_q       <= seg_d;
            dig_q       <= dig_d;
            frame_q     <= frame_d;
        end
    end

    assign seg   = seg_q;
    assign dig   = dig_q;
    assign frame = frame_q;

endmodule
